// File: rtl/spi_pixel_queue_if.sv
// Byte-stream input and pixel-FIFO output bundle for spi_pixel_queue.
// The slave modport is the queue itself; the master modport is the SPI feeder and arbiter side.
interface spi_pixel_queue_if #(
  parameter int ADDR_W = 4
);
  logic              spi_frame_start;
  logic              spi_byte_valid;
  logic [7:0]        spi_byte;
  logic [37:0]       pixel_data;
  logic              pixel_ready;
  logic              pixel_read;
  logic              frame_done;
  logic              overflow;
  logic [ADDR_W:0]   fill_level;

  modport master (
    output spi_frame_start, spi_byte_valid, spi_byte, pixel_read,
    input  pixel_data, pixel_ready, frame_done, overflow, fill_level
  );

  modport slave (
    input  spi_frame_start, spi_byte_valid, spi_byte, pixel_read,
    output pixel_data, pixel_ready, frame_done, overflow, fill_level
  );
endinterface

// File: rtl/spi_pixel_queue.sv
// Assembles SPI byte pairs into RGB565 pixels, tags them with raster x/y and queues them in a FWFT FIFO.
// Optional SPI_QUEUE_DROP_COUNT_EN adds a saturating dropped_count output.
module spi_pixel_queue #(
  parameter int X_RES  = 800,
  parameter int Y_RES  = 600,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_pixel_queue_if.slave   bus
`ifdef SPI_QUEUE_DROP_COUNT_EN
  ,
  output logic [15:0]        dropped_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;

  localparam logic [10:0]     X_LAST = 11'(X_RES - 1);
  localparam logic [10:0]     Y_LAST = 11'(Y_RES - 1);
  localparam logic [ADDR_W:0] FULL   = (ADDR_W + 1)'(DEPTH);

  state_t              r_state, w_state_next;
  logic [10:0]         r_x, r_y;
  logic [7:0]          r_hi;
  logic                r_frame_done;
  logic                r_overflow;
  logic [37:0]         r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]     r_count;

  logic w_hi_load, w_push, w_last;
  logic w_empty, w_full, w_pop, w_wr, w_drop;

  assign w_last  = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL);
  assign w_pop   = bus.pixel_read && !w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // frame_start overrides any byte strobe in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_hi_load    = 1'b0;
    w_push       = 1'b0;
    if (bus.spi_frame_start) begin
      w_state_next = S_HI;
    end else if (bus.spi_byte_valid) begin
      case (r_state)
        S_HI: begin
          w_hi_load    = 1'b1;
          w_state_next = S_LO;
        end
        S_LO: begin
          w_push       = 1'b1;
          w_state_next = w_last ? S_IDLE : S_HI;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_hi         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= w_push && w_last;
      if (bus.spi_frame_start) begin
        r_x  <= '0;
        r_y  <= '0;
        r_hi <= '0;
      end else begin
        if (w_hi_load)
          r_hi <= bus.spi_byte;
        // Raster advances even for dropped pixels so later coordinates stay right.
        if (w_push) begin
          if (w_last) begin
            r_x <= '0;
            r_y <= '0;
          end else if (r_x != X_LAST) begin
            r_x <= r_x + 11'd1;
          end else begin
            r_x <= '0;
            r_y <= r_y + 11'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= {r_x, r_y, r_hi, bus.spi_byte};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (bus.spi_frame_start)
        r_overflow <= 1'b0;
      else if (w_drop)
        r_overflow <= 1'b1;
    end
  end

`ifdef SPI_QUEUE_DROP_COUNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_drop_cnt <= '0;
    else if (bus.spi_frame_start)
      r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF))
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign dropped_count = r_drop_cnt;
`endif

  assign bus.pixel_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.pixel_ready = !w_empty;
  assign bus.frame_done  = r_frame_done;
  assign bus.overflow    = r_overflow;
  assign bus.fill_level  = r_count;

endmodule

// File: tb/tb_spi_pixel_queue.sv
// Directed bench for spi_pixel_queue: a 4x2 raster with a 16-deep FIFO (dut_a) and a 4-deep FIFO (dut_b).
module tb_spi_pixel_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  spi_pixel_queue_if #(.ADDR_W(4)) ifa ();
  spi_pixel_queue_if #(.ADDR_W(2)) ifb ();

`ifdef SPI_QUEUE_DROP_COUNT_EN
  logic [15:0] dc_a, dc_b;
`endif

  spi_pixel_queue #(.X_RES(4), .Y_RES(2), .DEPTH(16), .ADDR_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
`ifdef SPI_QUEUE_DROP_COUNT_EN
    , .dropped_count(dc_a)
`endif
  );

  spi_pixel_queue #(.X_RES(4), .Y_RES(2), .DEPTH(4), .ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
`ifdef SPI_QUEUE_DROP_COUNT_EN
    , .dropped_count(dc_b)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    ifa.spi_frame_start = 1'b1; cyc(); ifa.spi_frame_start = 1'b0;
  endtask
  task automatic byte_a(input logic [7:0] b);
    ifa.spi_byte = b; ifa.spi_byte_valid = 1'b1; cyc(); ifa.spi_byte_valid = 1'b0;
  endtask
  task automatic pix_a(input logic [15:0] p);
    byte_a(p[15:8]); byte_a(p[7:0]);
  endtask
  task automatic read_a();
    ifa.pixel_read = 1'b1; cyc(); ifa.pixel_read = 1'b0;
  endtask

  task automatic start_b();
    ifb.spi_frame_start = 1'b1; cyc(); ifb.spi_frame_start = 1'b0;
  endtask
  task automatic byte_b(input logic [7:0] b);
    ifb.spi_byte = b; ifb.spi_byte_valid = 1'b1; cyc(); ifb.spi_byte_valid = 1'b0;
  endtask
  task automatic pix_b(input logic [15:0] p);
    byte_b(p[15:8]); byte_b(p[7:0]);
  endtask
  task automatic read_b();
    ifb.pixel_read = 1'b1; cyc(); ifb.pixel_read = 1'b0;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    n_tests++; if (ifa.pixel_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ifa.pixel_ready); end
    n_tests++; if (ifa.fill_level !== 5'd0) begin n_fail++; $display("FAIL reset_fill got %0d want 0", ifa.fill_level); end
    n_tests++; if (ifa.pixel_data !== 38'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", ifa.pixel_data); end
    n_tests++; if (ifa.frame_done !== 1'b0 || ifa.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags got fd=%b ov=%b want 0 0", ifa.frame_done, ifa.overflow); end
    n_tests++; if (ifb.fill_level !== 3'd0 || ifb.pixel_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b got fill=%0d rdy=%b want 0 0", ifb.fill_level, ifb.pixel_ready); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    start_a();
    byte_a(8'hF8);
    n_tests++; if (ifa.pixel_ready !== 1'b0) begin n_fail++; $display("FAIL basic_hi_only got rdy=%b want 0", ifa.pixel_ready); end
    byte_a(8'h00);
    n_tests++; if (ifa.pixel_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %b want 1", ifa.pixel_ready); end
    n_tests++; if (ifa.pixel_data !== {11'd0, 11'd0, 16'hF800}) begin n_fail++; $display("FAIL basic_data got %h want %h", ifa.pixel_data, {11'd0, 11'd0, 16'hF800}); end
    read_a();
    n_tests++; if (ifa.pixel_ready !== 1'b0 || ifa.fill_level !== 5'd0) begin n_fail++; $display("FAIL basic_pop got rdy=%b fill=%0d want 0 0", ifa.pixel_ready, ifa.fill_level); end
  endtask

  task automatic test_frame();
    logic [37:0] exp;
    start_a();
    for (int k = 0; k < 8; k++) begin
      byte_a(8'(16 + k));
      byte_a(8'(32 + k));
      n_tests++; if (ifa.frame_done !== (k == 7)) begin n_fail++; $display("FAIL frame_done_%0d got %b want %b", k, ifa.frame_done, (k == 7)); end
    end
    cyc();
    n_tests++; if (ifa.frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_pulse got %b want 0", ifa.frame_done); end
    byte_a(8'hEE);
    byte_a(8'hEF);
    n_tests++; if (ifa.fill_level !== 5'd8) begin n_fail++; $display("FAIL frame_fill got %0d want 8", ifa.fill_level); end
    for (int k = 0; k < 8; k++) begin
      exp = {11'(k % 4), 11'(k / 4), 8'(16 + k), 8'(32 + k)};
      n_tests++; if (ifa.pixel_data !== exp) begin n_fail++; $display("FAIL frame_head_%0d got %h want %h", k, ifa.pixel_data, exp); end
      read_a();
    end
    n_tests++; if (ifa.fill_level !== 5'd0) begin n_fail++; $display("FAIL frame_drain got %0d want 0", ifa.fill_level); end
  endtask

  task automatic test_overflow();
    logic [37:0] exp;
    start_b();
    for (int k = 0; k < 6; k++) pix_b(16'(16'hA000 + k));
    n_tests++; if (ifb.fill_level !== 3'd4) begin n_fail++; $display("FAIL ovf_fill got %0d want 4", ifb.fill_level); end
    n_tests++; if (ifb.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", ifb.overflow); end
`ifdef SPI_QUEUE_DROP_COUNT_EN
    n_tests++; if (dc_b !== 16'd2) begin n_fail++; $display("FAIL ovf_dropcnt got %0d want 2", dc_b); end
`endif
    for (int k = 0; k < 4; k++) begin
      exp = {11'(k), 11'd0, 16'(16'hA000 + k)};
      n_tests++; if (ifb.pixel_data !== exp) begin n_fail++; $display("FAIL ovf_head_%0d got %h want %h", k, ifb.pixel_data, exp); end
      read_b();
    end
    n_tests++; if (ifb.pixel_ready !== 1'b0 || ifb.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got rdy=%b ov=%b want 0 1", ifb.pixel_ready, ifb.overflow); end
    pix_b(16'hA006);
    n_tests++; if (ifb.pixel_data !== {11'd2, 11'd1, 16'hA006}) begin n_fail++; $display("FAIL ovf_raster got %h want %h", ifb.pixel_data, {11'd2, 11'd1, 16'hA006}); end
    read_b();
    start_b();
    n_tests++; if (ifb.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", ifb.overflow); end
`ifdef SPI_QUEUE_DROP_COUNT_EN
    n_tests++; if (dc_b !== 16'd0) begin n_fail++; $display("FAIL ovf_dropcnt_clear got %0d want 0", dc_b); end
`endif
    pix_b(16'hBEEF);
    n_tests++; if (ifb.pixel_data !== {11'd0, 11'd0, 16'hBEEF}) begin n_fail++; $display("FAIL ovf_newframe got %h want %h", ifb.pixel_data, {11'd0, 11'd0, 16'hBEEF}); end
    read_b();
  endtask

  task automatic test_full_pop();
    logic [37:0] exp;
    start_b();
    for (int k = 0; k < 4; k++) pix_b(16'(16'hC000 + k));
    byte_b(8'hC0);
    ifb.spi_byte = 8'h04; ifb.spi_byte_valid = 1'b1; ifb.pixel_read = 1'b1;
    cyc();
    ifb.spi_byte_valid = 1'b0; ifb.pixel_read = 1'b0;
    n_tests++; if (ifb.fill_level !== 3'd4 || ifb.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop got fill=%0d ov=%b want 4 0", ifb.fill_level, ifb.overflow); end
    for (int k = 1; k < 5; k++) begin
      exp = {11'(k % 4), 11'(k / 4), 16'(16'hC000 + k)};
      n_tests++; if (ifb.pixel_data !== exp) begin n_fail++; $display("FAIL fullpop_head_%0d got %h want %h", k, ifb.pixel_data, exp); end
      read_b();
    end
    n_tests++; if (ifb.fill_level !== 3'd0) begin n_fail++; $display("FAIL fullpop_drain got %0d want 0", ifb.fill_level); end
  endtask

  task automatic test_empty_pop();
    start_a();
    byte_a(8'h5A);
    ifa.spi_byte = 8'hA5; ifa.spi_byte_valid = 1'b1; ifa.pixel_read = 1'b1;
    cyc();
    ifa.spi_byte_valid = 1'b0; ifa.pixel_read = 1'b0;
    n_tests++; if (ifa.fill_level !== 5'd1) begin n_fail++; $display("FAIL emptypop_fill got %0d want 1", ifa.fill_level); end
    n_tests++; if (ifa.pixel_data !== {11'd0, 11'd0, 16'h5AA5}) begin n_fail++; $display("FAIL emptypop_data got %h want %h", ifa.pixel_data, {11'd0, 11'd0, 16'h5AA5}); end
    read_a();
  endtask

  task automatic test_partial();
    start_a();
    byte_a(8'hAB);
    start_a();
    pix_a(16'h1234);
    n_tests++; if (ifa.fill_level !== 5'd1) begin n_fail++; $display("FAIL partial_fill got %0d want 1", ifa.fill_level); end
    n_tests++; if (ifa.pixel_data !== {11'd0, 11'd0, 16'h1234}) begin n_fail++; $display("FAIL partial_data got %h want %h", ifa.pixel_data, {11'd0, 11'd0, 16'h1234}); end
    read_a();
  endtask

  task automatic test_start_priority();
    start_a();
    byte_a(8'h55);
    ifa.spi_frame_start = 1'b1; ifa.spi_byte = 8'h66; ifa.spi_byte_valid = 1'b1;
    cyc();
    ifa.spi_frame_start = 1'b0; ifa.spi_byte_valid = 1'b0;
    n_tests++; if (ifa.fill_level !== 5'd0) begin n_fail++; $display("FAIL prio_nopush got %0d want 0", ifa.fill_level); end
    pix_a(16'h7788);
    n_tests++; if (ifa.pixel_data !== {11'd0, 11'd0, 16'h7788}) begin n_fail++; $display("FAIL prio_data got %h want %h", ifa.pixel_data, {11'd0, 11'd0, 16'h7788}); end
  endtask

  task automatic test_async_reset();
    pix_a(16'h0102);
    pix_a(16'h0304);
    n_tests++; if (ifa.fill_level !== 5'd3) begin n_fail++; $display("FAIL arst_prefill got %0d want 3", ifa.fill_level); end
    start_b();
    for (int k = 0; k < 5; k++) pix_b(16'(k));
    n_tests++; if (ifb.overflow !== 1'b1) begin n_fail++; $display("FAIL arst_pre_ovf got %b want 1", ifb.overflow); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_tests++; if (ifa.pixel_ready !== 1'b0 || ifa.fill_level !== 5'd0 || ifa.overflow !== 1'b0) begin n_fail++; $display("FAIL arst_a got rdy=%b fill=%0d ov=%b want 0 0 0", ifa.pixel_ready, ifa.fill_level, ifa.overflow); end
    n_tests++; if (ifb.overflow !== 1'b0 || ifb.fill_level !== 3'd0 || ifb.pixel_data !== 38'd0) begin n_fail++; $display("FAIL arst_b got ov=%b fill=%0d data=%h want 0 0 0", ifb.overflow, ifb.fill_level, ifb.pixel_data); end
    cyc();
    rst_n = 1'b1;
    cyc();
    start_a();
    pix_a(16'h4242);
    n_tests++; if (ifa.pixel_data !== {11'd0, 11'd0, 16'h4242}) begin n_fail++; $display("FAIL arst_restart got %h want %h", ifa.pixel_data, {11'd0, 11'd0, 16'h4242}); end
  endtask

  initial begin
    ifa.spi_frame_start = 1'b0; ifa.spi_byte_valid = 1'b0; ifa.spi_byte = 8'h00; ifa.pixel_read = 1'b0;
    ifb.spi_frame_start = 1'b0; ifb.spi_byte_valid = 1'b0; ifb.spi_byte = 8'h00; ifb.pixel_read = 1'b0;
    test_reset();
    test_basic();
    test_frame();
    test_overflow();
    test_full_pop();
    test_empty_pop();
    test_partial();
    test_start_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_pixel_queue.md
Name: spi_pixel_queue

Overview:
- Upstream feeder for the SRAM write arbiter's SPI image path. It receives a raw SPI byte stream of RGB565 pixels and assembles byte pairs into pixels.
- It tags each pixel with raster x/y coordinates and buffers the tagged words in a small FIFO. The arbiter drains the FIFO whenever no foreground read request is active, so pixels arriving during read bursts are queued instead of lost.
- Output word format and ready/read handshake are identical to the ADC pixel FIFO port.

Parameters:
- X_RES, 800, image width in pixels; x wraps at X_RES-1.
- Y_RES, 600, image height in pixels; frame ends after pixel (X_RES-1, Y_RES-1).
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 4.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- spi_frame_start  in  1  one-cycle pulse; starts a new image at (0,0).
- spi_byte_valid  in  1  one-cycle strobe; spi_byte holds a new byte.
- spi_byte  in  8  received byte; first byte of a pixel is [15:8], second is [7:0].
- pixel_data  out  38  FIFO head: [37:27] x, [26:16] y, [15:0] RGB565.
- pixel_ready  out  1  FIFO non-empty.
- pixel_read  in  1  pop strobe from the arbiter; consumes the head this cycle.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is assembled.
- overflow  out  1  sticky; set when a pixel is dropped on a full FIFO.
- fill_level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, x=y=0, hi-byte register=0.
  - FIFO empty, fill_level=0, pixel_ready=0, frame_done=0, overflow=0.
- States:
  - IDLE: spi_byte_valid ignored. spi_frame_start -> HI.
  - HI: spi_byte_valid stores spi_byte as the high byte -> LO.
  - LO: spi_byte_valid forms {hi, spi_byte}, pushes {x[10:0], y[10:0], pixel}, advances the raster -> HI, or -> IDLE after the last pixel.
- spi_frame_start in any state:
  - -> HI; x=y=0; any partial high byte is discarded; overflow is cleared.
  - FIFO contents are NOT flushed.
  - Takes priority over spi_byte_valid in the same cycle; that byte is dropped.
- Raster advance:
  - x<X_RES-1: x++.
  - Else: x=0 and y++.
  - At (X_RES-1, Y_RES-1): frame_done=1 the following cycle, state -> IDLE, x=y=0.
- FIFO:
  - First-word-fall-through; pixel_data is valid whenever pixel_ready=1.
  - pixel_data is forced to 0 when the FIFO is empty.
- Latency: a pixel completed by the LO byte in cycle N appears at pixel_data with pixel_ready=1 in cycle N+1, assuming the FIFO was empty.
- pixel_read:
  - When pixel_ready=1, pops the head; the next entry or empty status is visible in the next cycle.
  - pixel_read while empty is ignored; pointers and fill_level are unchanged.
- Push on full:
  - Without a simultaneous pop: the pixel is dropped, overflow is set, and the raster still advances so later pixels keep correct coordinates.
  - With a simultaneous pop: the push is accepted and fill_level stays DEPTH.
- Push and pop in the same cycle while empty: the pop is ignored and the push is accepted; fill_level=1 next cycle.
- Pointer arithmetic:
  - Pointers are ADDR_W bits and wrap modulo DEPTH.
  - fill_level is tracked with ADDR_W+1 bits; full means fill_level==DEPTH.
- Reset mid-frame: all state is lost immediately, FIFO contents are discarded, and the outputs take their reset values.

Optional Feature:
- Macro: SPI_QUEUE_DROP_COUNT_EN.
- With the macro defined:
  - Adds output port dropped_count, 16 bits.
  - Counts pixels dropped on full-FIFO pushes.
  - Saturates at 16'hFFFF, cleared by spi_frame_start and by reset.
- Without the macro: the port and counter are absent; overflow remains the only drop indication.

Test Plan:
- Reset, frame_start, bytes 0xF8,0x00 -> next cycle pixel_ready=1, pixel_data={11'd0, 11'd0, 16'hF800}; one pixel_read -> pixel_ready=0, fill_level=0.
- X_RES=4, Y_RES=2: frame_start, 16 bytes, no reads, DEPTH=16 -> 8 entries with coordinates (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1); frame_done pulses once after byte 16; further bytes are ignored in IDLE.
- DEPTH=4, pixel_read held 0, 6 pixels pushed -> fill_level=4, overflow=1, dropped_count=2 (with macro); after 4 reads the heads are pixels 0..3 in order; the next frame's pixel 0 is tagged (0,0).
- Full FIFO with pixel_read asserted on the same cycle the LO byte arrives -> fill_level stays 4, overflow stays 0, and the new pixel appears last.
- frame_start one cycle after a lone high byte 0xAB, then bytes 0x12,0x34 -> single pixel 16'h1234 at (0,0); 0xAB never appears.
- frame_start and spi_byte_valid asserted in the same cycle -> that byte is dropped; rst_n pulsed low mid-frame with 3 queued entries -> pixel_ready=0, fill_level=0, overflow=0 asynchronously.
